// File: rtl/openmips_run_ctrl_pkg.sv
// Shared encodings for the OpenMIPS run controller: FSM states, checkpoint targets, results.
package openmips_run_ctrl_pkg;

    localparam int unsigned TGT_W = 2;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [2:0] {
        ST_HOLD = 3'd0,
        ST_RUN  = 3'd1,
        ST_PASS = 3'd2,
        ST_FAIL = 3'd3,
        ST_TOUT = 3'd4
    } run_state_e;

    typedef enum logic [TGT_W-1:0] {
        CHK_GPR = 2'd0,
        CHK_HI  = 2'd1,
        CHK_LO  = 2'd2
    } chk_tgt_e;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_PASS = 2'd1,
        RES_FAIL = 2'd2,
        RES_TOUT = 2'd3
    } run_res_e;

    // Result reported for a given controller state.
    function automatic run_res_e state_result(input run_state_e st);
        case (st)
            ST_PASS: return RES_PASS;
            ST_FAIL: return RES_FAIL;
            ST_TOUT: return RES_TOUT;
            default: return RES_NONE;
        endcase
    endfunction

endpackage

// File: rtl/openmips_run_ctrl_if.sv
// Checkpoint-configuration and writeback-monitor bundle for openmips_run_ctrl.
interface openmips_run_ctrl_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_CHK = 8
);
    localparam int unsigned IDX_W = $clog2(NUM_CHK);

    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [1:0]        cfg_tgt;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic [IDX_W:0]    cfg_len;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic              hilo_we;
    logic [DATA_W-1:0] hi_i;
    logic [DATA_W-1:0] lo_i;

    modport master (
        output cfg_we, cfg_idx, cfg_tgt, cfg_addr, cfg_data, cfg_len,
        output wb_we, wb_waddr, wb_wdata, hilo_we, hi_i, lo_i
    );

    modport slave (
        input cfg_we, cfg_idx, cfg_tgt, cfg_addr, cfg_data, cfg_len,
        input wb_we, wb_waddr, wb_wdata, hilo_we, hi_i, lo_i
    );

endinterface

// File: rtl/run_ctrl_chk_table.sv
// Checkpoint table: synchronous write port, combinational read at the current pointer.
// Target storage exists only when RUN_CTRL_HILO_EN is defined.
module run_ctrl_chk_table
    import openmips_run_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CHK = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    localparam int unsigned IDX_W  = $clog2(NUM_CHK)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
`ifdef RUN_CTRL_HILO_EN
    ,
    input  logic [TGT_W-1:0]  wtgt,
    output logic [TGT_W-1:0]  rtgt
`endif
);

    logic [ADDR_W-1:0] addr_q [NUM_CHK];
    logic [DATA_W-1:0] data_q [NUM_CHK];
    logic              wr_en_c;

    // Writes to indices beyond the table depth are dropped.
    assign wr_en_c = we && (32'(widx) < NUM_CHK);

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            addr_q[widx] <= waddr;
            data_q[widx] <= wdata;
        end
    end

    assign raddr = addr_q[ridx];
    assign rdata = data_q[ridx];

`ifdef RUN_CTRL_HILO_EN
    logic [TGT_W-1:0] tgt_q [NUM_CHK];

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            tgt_q[widx] <= wtgt;
        end
    end

    assign rtgt = tgt_q[ridx];
`endif

endmodule

// File: rtl/openmips_run_ctrl.sv
// Run controller and writeback self-checker for the OpenMIPS minimal SOPC.
// Define RUN_CTRL_HILO_EN to enable HI/LO checkpoints; otherwise every entry is a GPR check.
module openmips_run_ctrl
    import openmips_run_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned NUM_CHK        = 8,
    localparam int unsigned IDX_W         = $clog2(NUM_CHK)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   restart,
    openmips_run_ctrl_if.slave     bus,
    output logic                   core_rst,
    output logic                   done,
    output logic                   pass,
    output logic [IDX_W-1:0]       fail_idx,
    output logic [CNT_W-1:0]       cycle_cnt
);

    localparam int unsigned LEN_W  = IDX_W + 1;
    localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);

    run_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [LEN_W-1:0]  ptr_q, ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic [ADDR_W-1:0] ent_addr;
    logic [DATA_W-1:0] ent_data;
    logic [CNT_W-1:0]  cycle_nx_c;
    logic              cfg_wr_c;
    logic              hit_c;
    logic              eq_c;

    assign cfg_wr_c = bus.cfg_we && (state_q != ST_RUN);

`ifdef RUN_CTRL_HILO_EN
    logic [TGT_W-1:0] ent_tgt;
`endif

    run_ctrl_chk_table #(
        .NUM_CHK (NUM_CHK),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) u_table (
        .clk   (clk),
        .we    (cfg_wr_c),
        .widx  (bus.cfg_idx),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_data),
        .ridx  (ptr_q[IDX_W-1:0]),
        .raddr (ent_addr),
        .rdata (ent_data)
`ifdef RUN_CTRL_HILO_EN
        ,
        .wtgt  (bus.cfg_tgt),
        .rtgt  (ent_tgt)
`endif
    );

`ifndef RUN_CTRL_HILO_EN
    logic unused_hilo;
    assign unused_hilo = ^{bus.cfg_tgt, bus.hilo_we, bus.hi_i, bus.lo_i};
`endif

    // Does this cycle's write hit the current entry, and does its data agree?
    always_comb begin
        hit_c = 1'b0;
        eq_c  = 1'b0;
`ifdef RUN_CTRL_HILO_EN
        if (ent_tgt == CHK_HI) begin
            hit_c = bus.hilo_we;
            eq_c  = (bus.hi_i == ent_data);
        end else if (ent_tgt == CHK_LO) begin
            hit_c = bus.hilo_we;
            eq_c  = (bus.lo_i == ent_data);
        end else begin
`endif
            // $0 is hardwired, so writes to it never count as a checkpoint.
            hit_c = bus.wb_we && (bus.wb_waddr == ent_addr) && (bus.wb_waddr != '0);
            eq_c  = (bus.wb_wdata == ent_data);
`ifdef RUN_CTRL_HILO_EN
        end
`endif
    end

    // Next-state, counters and registered outputs.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        cycle_cnt_d = cycle_cnt_q;
        fail_idx_d  = fail_idx_q;
        cycle_nx_c  = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);

        if (cfg_wr_c) begin
            len_d = (32'(bus.cfg_len) > NUM_CHK) ? LEN_W'(NUM_CHK) : bus.cfg_len;
        end

        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                cycle_cnt_d = cycle_nx_c;
                // Pass, then a checkpoint verdict, then timeout.
                if (ptr_q >= len_q) begin
                    state_d = ST_PASS;
                end else if (hit_c && !eq_c) begin
                    state_d    = ST_FAIL;
                    fail_idx_d = ptr_q[IDX_W-1:0];
                end else if (hit_c) begin
                    ptr_d = ptr_q + LEN_W'(1);
                end else if (cycle_nx_c >= CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d = ST_TOUT;
                end
            end
            ST_PASS, ST_FAIL, ST_TOUT: begin
                if (restart) begin
                    state_d     = ST_HOLD;
                    hold_cnt_d  = '0;
                    ptr_d       = '0;
                    cycle_cnt_d = '0;
                    fail_idx_d  = '0;
                end
            end
            default: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
        endcase

        core_rst_d = (state_d == ST_HOLD);
        done_d     = (state_result(state_d) != RES_NONE);
        pass_d     = (state_result(state_d) == RES_PASS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            ptr_q       <= '0;
            cycle_cnt_q <= '0;
            fail_idx_q  <= '0;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            ptr_q       <= ptr_d;
            cycle_cnt_q <= cycle_cnt_d;
            fail_idx_q  <= fail_idx_d;
            core_rst_q  <= core_rst_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    // Active entry count survives rst, like the table itself.
    always_ff @(posedge clk) begin
        len_q <= len_d;
    end

    assign core_rst  = core_rst_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_idx  = fail_idx_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_openmips_run_ctrl.sv
// Directed bench for openmips_run_ctrl: reset/hold timing, pass, fail, timeout, restart, rst mid-run.
module tb_openmips_run_ctrl;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned ADDR_W         = 5;
    localparam int unsigned NUM_CHK        = 8;
    localparam int unsigned IDX_W          = 3;
    localparam int unsigned RST_CYCLES     = 10;
    localparam int unsigned TIMEOUT_CYCLES = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             restart = 1'b0;
    logic             core_rst;
    logic             done;
    logic             pass;
    logic [IDX_W-1:0] fail_idx;
    logic [31:0]      cycle_cnt;

    int n_chk = 0;
    int n_err = 0;

    openmips_run_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CHK(NUM_CHK)) bus ();

    openmips_run_ctrl #(
        .RST_CYCLES     (RST_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .NUM_CHK        (NUM_CHK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .bus       (bus),
        .core_rst  (core_rst),
        .done      (done),
        .pass      (pass),
        .fail_idx  (fail_idx),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        e_done;
        logic        e_pass;
        logic [2:0]  e_fidx;
        logic [31:0] e_cyc;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic configure(input logic [2:0] idx, input logic [1:0] tgt, input logic [4:0] addr,
                             input logic [31:0] data, input logic [3:0] len);
        bus.cfg_we   = 1'b1;
        bus.cfg_idx  = idx;
        bus.cfg_tgt  = tgt;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        bus.cfg_len  = len;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic gpr_write(input logic [4:0] addr, input logic [31:0] data);
        bus.wb_we    = 1'b1;
        bus.wb_waddr = addr;
        bus.wb_wdata = data;
        tick();
        bus.wb_we    = 1'b0;
    endtask

    // Counts core_rst-high cycles until the run phase starts (bounded).
    task automatic hold_check(input string nm);
        int n = 0;
        while (core_rst === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({nm, ".hold_cycles"}, 32'(n), 32'(RST_CYCLES));
        chk({nm, ".run_done"}, 32'(done), 32'd0);
        chk({nm, ".run_cyc"}, cycle_cnt, 32'd0);
    endtask

    task automatic restart_seq(input string nm);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk({nm, ".core_rst"}, 32'(core_rst), 32'd1);
        chk({nm, ".done"}, 32'(done), 32'd0);
        chk({nm, ".pass"}, 32'(pass), 32'd0);
        chk({nm, ".fidx"}, 32'(fail_idx), 32'd0);
        chk({nm, ".cyc"}, cycle_cnt, 32'd0);
        hold_check(nm);
    endtask

    task automatic apply_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            bus.wb_we    = vecs[i].we;
            bus.wb_waddr = vecs[i].addr;
            bus.wb_wdata = vecs[i].data;
            tick();
            chk($sformatf("v%0d.done", i), 32'(done), 32'(vecs[i].e_done));
            chk($sformatf("v%0d.pass", i), 32'(pass), 32'(vecs[i].e_pass));
            chk($sformatf("v%0d.fidx", i), 32'(fail_idx), 32'(vecs[i].e_fidx));
            chk($sformatf("v%0d.cyc", i), cycle_cnt, vecs[i].e_cyc);
            chk($sformatf("v%0d.core_rst", i), 32'(core_rst), 32'd0);
        end
        bus.wb_we = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        // Pass run: ignored writes ($3, wrong data to an already-consumed $1, $0), then $2 completes.
        vecs[0]  = '{1'b1, 5'd3, 32'd7,          1'b0, 1'b0, 3'd0, 32'd1};
        vecs[1]  = '{1'b1, 5'd1, 32'h0000_FFFF,  1'b0, 1'b0, 3'd0, 32'd2};
        vecs[2]  = '{1'b1, 5'd1, 32'd0,          1'b0, 1'b0, 3'd0, 32'd3};
        vecs[3]  = '{1'b1, 5'd0, 32'd5,          1'b0, 1'b0, 3'd0, 32'd4};
        vecs[4]  = '{1'b1, 5'd2, 32'd5,          1'b0, 1'b0, 3'd0, 32'd5};
        vecs[5]  = '{1'b0, 5'd0, 32'd0,          1'b1, 1'b1, 3'd0, 32'd6};
        vecs[6]  = '{1'b1, 5'd2, 32'd9,          1'b1, 1'b1, 3'd0, 32'd6};
        // Fail run: $2 carries 6 instead of 5.
        vecs[7]  = '{1'b1, 5'd1, 32'h0000_FFFF,  1'b0, 1'b0, 3'd0, 32'd1};
        vecs[8]  = '{1'b0, 5'd0, 32'd0,          1'b0, 1'b0, 3'd0, 32'd2};
        vecs[9]  = '{1'b1, 5'd2, 32'd6,          1'b1, 1'b0, 3'd1, 32'd3};
        vecs[10] = '{1'b0, 5'd0, 32'd0,          1'b1, 1'b0, 3'd1, 32'd3};

        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_tgt = '0; bus.cfg_addr = '0;
        bus.cfg_data = '0; bus.cfg_len = '0;
        bus.wb_we = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0;
        bus.hilo_we = 1'b0; bus.hi_i = '0; bus.lo_i = '0;

        rst = 1'b1;
        tick();
        chk("rst.core_rst", 32'(core_rst), 32'd1);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.pass", 32'(pass), 32'd0);
        chk("rst.fidx", 32'(fail_idx), 32'd0);
        chk("rst.cyc", cycle_cnt, 32'd0);

        configure(3'd0, 2'd0, 5'd1, 32'h0000_FFFF, 4'd2);
        configure(3'd1, 2'd0, 5'd2, 32'd5, 4'd2);
        rst = 1'b0;
        hold_check("first");
        apply_vecs(0, 6);

        restart_seq("rs_fail");
        apply_vecs(7, 10);

        // Timeout; a restart pulse during RUN must be ignored.
        restart_seq("rs_tout");
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("run_restart.core_rst", 32'(core_rst), 32'd0);
        chk("run_restart.cyc", cycle_cnt, 32'd1);
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("tout.cycles", 32'(n), 32'(TIMEOUT_CYCLES));
        chk("tout.done", 32'(done), 32'd1);
        chk("tout.pass", 32'(pass), 32'd0);
        chk("tout.fidx", 32'(fail_idx), 32'd0);
        chk("tout.cyc", cycle_cnt, 32'd64);
        tick();
        chk("tout.sticky_cyc", cycle_cnt, 32'd64);

        // Match on the last allowed cycle beats the timeout.
        configure(3'd0, 2'd0, 5'd4, 32'h44, 4'd1);
        restart_seq("rs_prio");
        for (int i = 0; i < 63; i++) tick();
        chk("prio.cyc63", cycle_cnt, 32'd63);
        chk("prio.done63", 32'(done), 32'd0);
        gpr_write(5'd4, 32'h44);
        chk("prio.done64", 32'(done), 32'd0);
        chk("prio.cyc64", cycle_cnt, 32'd64);
        tick();
        chk("prio.pass", 32'(pass), 32'd1);
        chk("prio.cyc65", cycle_cnt, 32'd65);

        // cfg_len = 0 passes one cycle after RUN entry.
        configure(3'd0, 2'd0, 5'd0, 32'd0, 4'd0);
        restart_seq("rs_len0");
        tick();
        chk("len0.pass", 32'(pass), 32'd1);
        chk("len0.cyc", cycle_cnt, 32'd1);

        // rst mid-RUN after entry 0 matched: check restarts from entry 0.
        configure(3'd0, 2'd0, 5'd1, 32'h0000_FFFF, 4'd2);
        configure(3'd1, 2'd0, 5'd2, 32'd5, 4'd2);
        restart_seq("rs_mid");
        gpr_write(5'd1, 32'h0000_FFFF);
        rst = 1'b1;
        tick();
        chk("midrst.core_rst", 32'(core_rst), 32'd1);
        chk("midrst.cyc", cycle_cnt, 32'd0);
        rst = 1'b0;
        hold_check("midrst");
        gpr_write(5'd2, 32'd5);
        tick();
        tick();
        chk("midrst.no_pass_done", 32'(done), 32'd0);
        chk("midrst.cyc3", cycle_cnt, 32'd3);
        gpr_write(5'd1, 32'h0000_FFFF);
        gpr_write(5'd2, 32'd5);
        tick();
        chk("midrst.pass", 32'(pass), 32'd1);
        chk("midrst.cyc6", cycle_cnt, 32'd6);

`ifdef RUN_CTRL_HILO_EN
        configure(3'd0, 2'd1, 5'd0, 32'hFFFF_FFFF, 4'd2);
        configure(3'd1, 2'd2, 5'd0, 32'd2, 4'd2);
        restart_seq("rs_hilo");
        bus.hilo_we = 1'b1;
        bus.hi_i    = 32'hFFFF_FFFF;
        bus.lo_i    = 32'd2;
        tick();
        chk("hilo.done1", 32'(done), 32'd0);
        tick();
        chk("hilo.done2", 32'(done), 32'd0);
        bus.hilo_we = 1'b0;
        tick();
        chk("hilo.pass", 32'(pass), 32'd1);
        chk("hilo.cyc", cycle_cnt, 32'd3);
`else
        // Without HI/LO support a HI-tagged entry is checked as a GPR write.
        configure(3'd0, 2'd1, 5'd6, 32'h66, 4'd1);
        restart_seq("rs_gpronly");
        bus.hilo_we = 1'b1;
        bus.hi_i    = 32'h66;
        bus.lo_i    = 32'h66;
        tick();
        bus.hilo_we = 1'b0;
        chk("gpronly.hilo_ignored", 32'(done), 32'd0);
        gpr_write(5'd6, 32'h66);
        tick();
        chk("gpronly.pass", 32'(pass), 32'd1);
        chk("gpronly.cyc", cycle_cnt, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/openmips_run_ctrl.md
Name: openmips_run_ctrl

Overview:
- Synthesizable run controller and self-checker for the OpenMIPS minimal SOPC.
- Generates the core reset sequence with a parametrised duration and enforces a cycle timeout.
- Monitors the writeback port and checks it against an ordered table of expected register writes, then reports pass, fail or timeout.
- Sits beside openmips_min_sopc, so regression benches and FPGA bring-up share one checker.

Parameters:
- RST_CYCLES, 10: cycles core_rst is held asserted after the controller leaves reset or restarts.
- TIMEOUT_CYCLES, 64: RUN-phase cycles allowed before TIMEOUT.
- DATA_W, 32: writeback data width.
- ADDR_W, 5: GPR address width.
- NUM_CHK, 8: checkpoint table depth; must be 2..256.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- restart  in  1  one-cycle pulse; honoured only in PASS, FAIL or TOUT.
- cfg_we  in  1  checkpoint table write strobe; ignored in RUN.
- cfg_idx  in  $clog2(NUM_CHK)  table entry to write.
- cfg_tgt  in  2  target: 0 = GPR, 1 = HI, 2 = LO.
- cfg_addr  in  ADDR_W  expected GPR address.
- cfg_data  in  DATA_W  expected value.
- cfg_len  in  $clog2(NUM_CHK)+1  active entries; sampled when cfg_we is high.
- wb_we  in  1  core GPR writeback enable.
- wb_waddr  in  ADDR_W  GPR writeback address.
- wb_wdata  in  DATA_W  GPR writeback data.
- hilo_we  in  1  HI/LO write enable.
- hi_i  in  DATA_W  HI write data.
- lo_i  in  DATA_W  LO write data.
- core_rst  out  1  reset to the SOPC; active-high, equal to `RstEnable.
- done  out  1  high in PASS, FAIL or TOUT.
- pass  out  1  high in PASS only.
- fail_idx  out  $clog2(NUM_CHK)  entry that mismatched; 0 otherwise.
- cycle_cnt  out  32  RUN-phase cycle counter.

Behaviour:
- Reset: rst synchronously puts the FSM in HOLD and clears every counter.
  - Output reset values: core_rst = 1, done = 0, pass = 0, fail_idx = 0, cycle_cnt = 0.
  - Table contents and cfg_len are not cleared by rst.
- FSM states are HOLD, RUN, PASS, FAIL and TOUT.
- HOLD:
  - core_rst = 1 and the hold counter increments each cycle.
  - After exactly RST_CYCLES cycles in HOLD, move to RUN; core_rst goes 0 on the RUN entry edge.
- RUN:
  - cycle_cnt increments every cycle and saturates at all-ones.
  - ptr starts at 0 and indexes the current expected entry.
- GPR match, entry tgt = 0:
  - Applies to a wb_we cycle with wb_waddr equal to the entry's address.
  - Data equal: ptr increments.
  - Data unequal: go to FAIL with fail_idx = ptr.
  - Writes to other addresses are ignored, and so is any write to $0.
- HI/LO match, entry tgt = 1 or 2: applies to hilo_we cycles, comparing hi_i or lo_i; equal/unequal handling is the same as for GPR.
- Only one checkpoint is consumed per cycle. If both a GPR and a HI/LO write occur, only the current entry's target is evaluated.
- Pass: when ptr reaches cfg_len, go to PASS on the next edge.
  - cfg_len = 0 passes one cycle after RUN entry.
- Timeout: when cycle_cnt reaches TIMEOUT_CYCLES with no pass/fail, go to TOUT.
  - A match/mismatch in that same cycle takes priority over the timeout.
- Terminal states (PASS, FAIL, TOUT):
  - Each is sticky; core_rst stays 0, so the core keeps running and is no longer checked.
  - restart goes to HOLD and clears ptr, cycle_cnt and fail_idx.
- rst asserted mid-RUN: the controller immediately returns to HOLD and the check restarts from entry 0.
- cfg_we in HOLD or a terminal state: the table entry is written on the edge and usable in the next RUN.

Optional Feature:
- Macro: RUN_CTRL_HILO_EN.
- Defined: HI/LO checkpoints are enabled as described above.
- Undefined:
  - cfg_tgt is ignored and every entry is treated as GPR.
  - hilo_we, hi_i and lo_i are left unconnected internally.
  - Target storage is not instantiated.

Decomposition:
- Shared package (alongside define.v): state encodings, target codes CHK_GPR, CHK_HI and CHK_LO, and the result encoding.
- Sub-module run_ctrl_chk_table: NUM_CHK-entry register array with a synchronous write port and a combinational read at ptr.

Test Plan:
- RST_CYCLES = 10 → core_rst is high for exactly 10 cycles after rst falls; done = 0 during RUN.
- Table {($1, 0x0000FFFF), ($2, 0x00000005)}, cfg_len = 2; bench writes $3 = 7, then $1 = 0x0000FFFF, then $2 = 5 → pass = 1 one cycle after the $2 write; cycle_cnt frozen.
- Same table, but $2 = 6 → FAIL with fail_idx = 1 and pass = 0.
- With RUN_CTRL_HILO_EN: entry (HI, 0xFFFFFFFF), then (LO, 0x00000002); hilo_we with hi_i = 0xFFFFFFFF and lo_i = 2 → first entry matches, second is consumed on the next hilo_we carrying lo_i = 2 → PASS.
- TIMEOUT_CYCLES = 64 and no writes → TOUT at cycle_cnt = 64; restart → HOLD, with core_rst high for 10 cycles again.
- rst pulsed mid-RUN after entry 0 has matched → HOLD, ptr = 0; the run then passes only if entry 0 is matched again.
